// File: rtl/duck_round_scheduler.sv
// Duck-hunt round sequencer: paces each duck through gap, flight and fall, tallies hits and decides pass/fail/win per round.
// Optional macro DUCK_SPEEDUP_EN shortens the flight time as rounds advance (adds FLIGHT_STEP/FLIGHT_MIN).
module duck_round_scheduler #(
    parameter int DUCKS_PER_ROUND = 10,
    parameter int HITS_TO_PASS    = 6,
    parameter int MAX_ROUNDS      = 9,
    parameter int FLIGHT_TIME     = 400,
    parameter int FALL_TIME       = 20,
    parameter int GAP_TIME        = 10,
    parameter int SPAWN_X_MAX     = 927
`ifdef DUCK_SPEEDUP_EN
    ,
    parameter int FLIGHT_STEP     = 30,
    parameter int FLIGHT_MIN      = 100
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        game_enable,
    input  logic        duck_hit,
    input  logic [9:0]  lfsr_number,
    output logic        spawn_valid,
    output logic [11:0] spawn_x,
    output logic        duck_active,
    output logic        duck_escaped,
    output logic [3:0]  round,
    output logic [3:0]  duck_idx,
    output logic [3:0]  round_hits,
    output logic        game_over,
    output logic        game_won
);

    localparam logic [15:0] GAP_LOAD    = 16'(GAP_TIME);
    localparam logic [15:0] FALL_LOAD   = 16'(FALL_TIME);
    localparam logic [3:0]  DUCKS_L     = 4'(DUCKS_PER_ROUND);
    localparam logic [3:0]  HITS_L      = 4'(HITS_TO_PASS);
    localparam logic [3:0]  MAX_ROUND_L = 4'(MAX_ROUNDS);
    localparam logic [11:0] SPAWN_MAX_L = 12'(SPAWN_X_MAX);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_GAP       = 3'd1,
        S_FLYING    = 3'd2,
        S_FALLING   = 3'd3,
        S_ROUND_END = 3'd4,
        S_GAME_OVER = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic        spawn_valid_q, spawn_valid_d;
    logic [11:0] spawn_x_q, spawn_x_d;
    logic        duck_active_q, duck_active_d;
    logic        duck_escaped_q, duck_escaped_d;
    logic [3:0]  round_q, round_d;
    logic [3:0]  duck_idx_q, duck_idx_d;
    logic [3:0]  round_hits_q, round_hits_d;
    logic        game_over_q, game_over_d;
    logic        game_won_q, game_won_d;

    logic [15:0] flight_load_s;
    logic [11:0] lfsr_ext_s;
    logic [11:0] spawn_pick_s;
    logic [3:0]  idx_inc_s;
    logic        round_full_s;

`ifdef DUCK_SPEEDUP_EN
    int dec_s;

    // Flight load shrinks by FLIGHT_STEP per round, floored at FLIGHT_MIN without going negative
    always_comb begin
        if (round_q == 4'd0) begin
            dec_s = 0;
        end else begin
            dec_s = (int'(round_q) - 1) * FLIGHT_STEP;
        end
        if (dec_s >= (FLIGHT_TIME - FLIGHT_MIN)) begin
            flight_load_s = 16'(FLIGHT_MIN);
        end else begin
            flight_load_s = 16'(FLIGHT_TIME - dec_s);
        end
    end
`else
    assign flight_load_s = 16'(FLIGHT_TIME);
`endif

    // Fold out-of-range random values back onto the screen
    always_comb begin
        lfsr_ext_s = {2'b00, lfsr_number};
        if (lfsr_ext_s <= SPAWN_MAX_L) begin
            spawn_pick_s = lfsr_ext_s;
        end else begin
            spawn_pick_s = lfsr_ext_s - 12'd512;
        end
    end

    assign idx_inc_s    = duck_idx_q + 4'd1;
    assign round_full_s = (idx_inc_s == DUCKS_L);

    // Next-state and next-output computation
    always_comb begin
        state_d        = state_q;
        timer_d        = 16'd0;
        spawn_valid_d  = 1'b0;
        spawn_x_d      = spawn_x_q;
        duck_escaped_d = 1'b0;
        round_d        = round_q;
        duck_idx_d     = duck_idx_q;
        round_hits_d   = round_hits_q;
        game_won_d     = game_won_q;

        if (timer_q != 16'd0) begin
            timer_d = timer_q - 16'd1;
        end else begin
            timer_d = 16'd0;
        end

        if ((state_q != S_IDLE) && !game_enable) begin
            // Abort drops any pulse that would have fired this edge
            state_d      = S_IDLE;
            timer_d      = 16'd0;
            spawn_x_d    = 12'd0;
            round_d      = 4'd0;
            duck_idx_d   = 4'd0;
            round_hits_d = 4'd0;
            game_won_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    spawn_x_d    = 12'd0;
                    duck_idx_d   = 4'd0;
                    round_hits_d = 4'd0;
                    game_won_d   = 1'b0;
                    if (game_enable) begin
                        state_d = S_GAP;
                        round_d = 4'd1;
                        timer_d = GAP_LOAD;
                    end else begin
                        round_d = 4'd0;
                        timer_d = 16'd0;
                    end
                end
                S_GAP: begin
                    if (timer_q == 16'd0) begin
                        state_d       = S_FLYING;
                        spawn_valid_d = 1'b1;
                        spawn_x_d     = spawn_pick_s;
                        timer_d       = flight_load_s;
                    end else begin
                        state_d = S_GAP;
                    end
                end
                S_FLYING: begin
                    if (duck_hit) begin
                        state_d      = S_FALLING;
                        round_hits_d = round_hits_q + 4'd1;
                        timer_d      = FALL_LOAD;
                    end else if (timer_q == 16'd0) begin
                        duck_escaped_d = 1'b1;
                        duck_idx_d     = idx_inc_s;
                        if (round_full_s) begin
                            state_d = S_ROUND_END;
                        end else begin
                            state_d = S_GAP;
                            timer_d = GAP_LOAD;
                        end
                    end else begin
                        state_d = S_FLYING;
                    end
                end
                S_FALLING: begin
                    if (timer_q == 16'd0) begin
                        duck_idx_d = idx_inc_s;
                        if (round_full_s) begin
                            state_d = S_ROUND_END;
                        end else begin
                            state_d = S_GAP;
                            timer_d = GAP_LOAD;
                        end
                    end else begin
                        state_d = S_FALLING;
                    end
                end
                S_ROUND_END: begin
                    if ((round_hits_q >= HITS_L) && (round_q < MAX_ROUND_L)) begin
                        state_d      = S_GAP;
                        round_d      = round_q + 4'd1;
                        duck_idx_d   = 4'd0;
                        round_hits_d = 4'd0;
                        timer_d      = GAP_LOAD;
                    end else if (round_hits_q >= HITS_L) begin
                        state_d    = S_GAME_OVER;
                        game_won_d = 1'b1;
                    end else begin
                        state_d    = S_GAME_OVER;
                        game_won_d = 1'b0;
                    end
                end
                S_GAME_OVER: begin
                    state_d = S_GAME_OVER;
                    timer_d = 16'd0;
                end
                default: begin
                    state_d = S_IDLE;
                    timer_d = 16'd0;
                end
            endcase
        end

        duck_active_d = (state_d == S_FLYING);
        game_over_d   = (state_d == S_GAME_OVER);
    end

    // State, timer and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            timer_q        <= 16'd0;
            spawn_valid_q  <= 1'b0;
            spawn_x_q      <= 12'd0;
            duck_active_q  <= 1'b0;
            duck_escaped_q <= 1'b0;
            round_q        <= 4'd0;
            duck_idx_q     <= 4'd0;
            round_hits_q   <= 4'd0;
            game_over_q    <= 1'b0;
            game_won_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            spawn_valid_q  <= spawn_valid_d;
            spawn_x_q      <= spawn_x_d;
            duck_active_q  <= duck_active_d;
            duck_escaped_q <= duck_escaped_d;
            round_q        <= round_d;
            duck_idx_q     <= duck_idx_d;
            round_hits_q   <= round_hits_d;
            game_over_q    <= game_over_d;
            game_won_q     <= game_won_d;
        end
    end

    assign spawn_valid  = spawn_valid_q;
    assign spawn_x      = spawn_x_q;
    assign duck_active  = duck_active_q;
    assign duck_escaped = duck_escaped_q;
    assign round        = round_q;
    assign duck_idx     = duck_idx_q;
    assign round_hits   = round_hits_q;
    assign game_over    = game_over_q;
    assign game_won     = game_won_q;

endmodule

// File: tb/tb_duck_round_scheduler.sv
// Directed bench for duck_round_scheduler: scoreboard queues hold expected spawn_x values and escape cycles.
module tb_duck_round_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        game_enable;
    logic        duck_hit;
    logic [9:0]  lfsr_number;
    logic        spawn_valid;
    logic [11:0] spawn_x;
    logic        duck_active;
    logic        duck_escaped;
    logic [3:0]  round;
    logic [3:0]  duck_idx;
    logic [3:0]  round_hits;
    logic        game_over;
    logic        game_won;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int exp_spawn_q[$];
    int exp_esc_q[$];

    duck_round_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .game_enable  (game_enable),
        .duck_hit     (duck_hit),
        .lfsr_number  (lfsr_number),
        .spawn_valid  (spawn_valid),
        .spawn_x      (spawn_x),
        .duck_active  (duck_active),
        .duck_escaped (duck_escaped),
        .round        (round),
        .duck_idx     (duck_idx),
        .round_hits   (round_hits),
        .game_over    (game_over),
        .game_won     (game_won)
    );

    always #5 clk = ~clk;

    // Cycle counter used to time escapes against spawns
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int model_x(input int v);
        return (v <= 927) ? v : v - 512;
    endfunction

    function automatic int flight_len(input int r);
        int f;
`ifdef DUCK_SPEEDUP_EN
        f = 400 - (r - 1) * 30;
        if (f < 100) f = 100;
`else
        f = 400;
`endif
        return f;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every spawn and escape pulse must match a queued expectation
    always @(negedge clk) begin
        if (spawn_valid === 1'b1) begin
            if (exp_spawn_q.size() == 0) check("spawn_unexpected", 32'd1, 32'd0);
            else check("spawn_x", {20'd0, spawn_x}, exp_spawn_q.pop_front());
        end
        if (duck_escaped === 1'b1) begin
            if (exp_esc_q.size() == 0) check("escape_unexpected", 32'd1, 32'd0);
            else check("escape_cycle", cyc, exp_esc_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic arm_spawn(input int v);
        lfsr_number = 10'(v);
        exp_spawn_q.push_back(model_x(v));
    endtask

    task automatic wait_spawn(output int s);
        int n;
        n = 0;
        while (spawn_valid !== 1'b1 && n < 600) begin
            tick();
            n++;
        end
        check("spawn_seen", {31'd0, spawn_valid}, 32'd1);
        s = cyc;
    endtask

    task automatic escape_duck(input int s, input int r, input int idx);
        int n;
        exp_esc_q.push_back(s + flight_len(r) + 1);
        n = 0;
        while (duck_escaped !== 1'b1 && n < 1000) begin
            tick();
            n++;
        end
        check("escape_seen", {31'd0, duck_escaped}, 32'd1);
        check("duck_idx_at_escape", {28'd0, duck_idx}, 32'(idx));
    endtask

    task automatic hit_duck(input int hits_exp);
        repeat (3) tick();
        check("active_before_hit", {31'd0, duck_active}, 32'd1);
        duck_hit = 1'b1;
        tick();
        duck_hit = 1'b0;
        check("hits_after_hit", {28'd0, round_hits}, 32'(hits_exp));
        check("inactive_after_hit", {31'd0, duck_active}, 32'd0);
    endtask

    function automatic logic [31:0] all_out();
        return {3'd0, spawn_valid, spawn_x, duck_active, duck_escaped, round,
                duck_idx, round_hits, game_over, game_won};
    endfunction

    initial begin
        int s;
        int vals[10];
        vals = '{1000, 927, 928, 0, 1023, 511, 512, 300, 800, 999};
        rst = 1'b1;
        game_enable = 1'b1;
        duck_hit = 1'b0;
        lfsr_number = 10'd0;

        // Reset with enable held high
        repeat (3) begin
            tick();
            check("reset_outputs", all_out(), 32'd0);
        end
        arm_spawn(vals[0]);
        rst = 1'b0;
        tick();
        check("start_round", {28'd0, round}, 32'd1);
        check("start_idx", {28'd0, duck_idx}, 32'd0);
        check("start_over", {31'd0, game_over}, 32'd0);
        for (int k = 1; k <= 11; k++) begin
            tick();
            check("spawn_pulse_time", {31'd0, spawn_valid}, {31'd0, k == 11});
        end
        s = cyc;

        // Game 1: every duck escapes
        escape_duck(s, 1, 1);
        check("spawn_x_held", {20'd0, spawn_x}, 32'd488);
        for (int d = 1; d < 10; d++) begin
            arm_spawn(vals[d]);
            wait_spawn(s);
            escape_duck(s, 1, d + 1);
        end
        tick();
        check("lose_over", {31'd0, game_over}, 32'd1);
        check("lose_won", {31'd0, game_won}, 32'd0);
        check("lose_round", {28'd0, round}, 32'd1);
        check("lose_hits", {28'd0, round_hits}, 32'd0);
        game_enable = 1'b0;
        tick();
        check("idle_after_lose", all_out(), 32'd0);

        // Game 2: six hits per round through the final round
        game_enable = 1'b1;
        tick();
        check("restart_round", {28'd0, round}, 32'd1);
        for (int r = 1; r <= 9; r++) begin
            for (int d = 0; d < 10; d++) begin
                arm_spawn((r * 131 + d * 97 + 3) % 1024);
                wait_spawn(s);
                if (r == 1 && d == 0) begin
                    repeat (400) tick();
                    check("active_at_timer0", {31'd0, duck_active}, 32'd1);
                    duck_hit = 1'b1;
                    tick();
                    duck_hit = 1'b0;
                    check("late_hit_counted", {28'd0, round_hits}, 32'd1);
                    check("late_hit_no_escape", {31'd0, duck_escaped}, 32'd0);
                    for (int k = 1; k <= 21; k++) begin
                        if (k == 10) duck_hit = 1'b1;
                        tick();
                        duck_hit = 1'b0;
                        check("fall_length", {28'd0, duck_idx}, {31'd0, k == 21});
                    end
                    check("fall_hit_ignored", {28'd0, round_hits}, 32'd1);
                end else if (d < 6) begin
                    hit_duck(d + 1);
                end else begin
                    escape_duck(s, r, d + 1);
                end
            end
            tick();
            if (r < 9) begin
                check("round_advance", {28'd0, round}, 32'(r + 1));
                check("round_hits_clear", {28'd0, round_hits}, 32'd0);
                check("round_idx_clear", {28'd0, duck_idx}, 32'd0);
                check("round_not_over", {31'd0, game_over}, 32'd0);
            end else begin
                check("win_over", {31'd0, game_over}, 32'd1);
                check("win_won", {31'd0, game_won}, 32'd1);
                check("win_round", {28'd0, round}, 32'd9);
                check("win_hits", {28'd0, round_hits}, 32'd6);
            end
        end
        repeat (3) tick();
        check("over_hold", {31'd0, game_over}, 32'd1);
        check("won_hold", {31'd0, game_won}, 32'd1);
        game_enable = 1'b0;
        tick();
        check("idle_after_win", all_out(), 32'd0);

        // Abort in mid-flight: no escape may follow
        game_enable = 1'b1;
        arm_spawn(600);
        tick();
        wait_spawn(s);
        repeat (50) tick();
        check("abort_active", {31'd0, duck_active}, 32'd1);
        game_enable = 1'b0;
        tick();
        check("abort_idle", all_out(), 32'd0);
        repeat (450) tick();
        check("escape_queue_empty", 32'(exp_esc_q.size()), 32'd0);
        check("spawn_queue_empty", 32'(exp_spawn_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/duck_round_scheduler.md
Name: duck_round_scheduler

Overview:
Sequences the duck-hunt game above the shot-resolution logic. Paces each duck through spawn, flight, fall and escape, counts hits per round, and advances rounds. Decides pass, fail and win at the end of each round. Sits between the game-enable/menu logic and the duck motion and shot logic; consumes a hit pulse and drives spawn and active strobes.

Parameters:
DUCKS_PER_ROUND, 10, ducks launched per round (1..15)
HITS_TO_PASS, 6, minimum hits in a round to advance
MAX_ROUNDS, 9, final round; passing it wins the game
FLIGHT_TIME, 400, cycles a duck stays shootable before escaping
FALL_TIME, 20, cycles of fall animation after a hit
GAP_TIME, 10, cycles between ducks
SPAWN_X_MAX, 927, largest legal spawn x (screen width minus duck width minus 1)

Ports:
clk  in  1  clock
rst  in  1  reset
game_enable  in  1  level; game runs while high
duck_hit  in  1  one-cycle pulse from shot logic: active duck was hit
lfsr_number  in  10  free-running random value
spawn_valid  out  1  one-cycle pulse: launch duck at spawn_x
spawn_x  out  12  latched spawn x position
duck_active  out  1  duck flying and shootable
duck_escaped  out  1  one-cycle pulse: duck left unhit
round  out  4  current round, 1-based (0 in IDLE)
duck_idx  out  4  ducks resolved in the current round
round_hits  out  4  hits in the current round
game_over  out  1  game ended (win or lose)
game_won  out  1  valid while game_over=1

Behaviour:
- Reset (rst, synchronous, active-high): state=IDLE. All outputs 0. Internal timer 0.
- All outputs are registered.
- Timer: loaded with T; decrements each cycle; the state exits on the cycle the timer reads 0. Each timed state therefore lasts T+1 cycles.
- IDLE: outputs 0. When game_enable=1, go to GAP next cycle with round=1, duck_idx=0, round_hits=0, timer=GAP_TIME.
- GAP: when the timer reaches 0, go to FLYING.
  - spawn_valid=1 for exactly the first FLYING cycle.
  - spawn_x = lfsr_number if ≤ SPAWN_X_MAX, else lfsr_number−512. Zero-extend to 12 bits. Sample on the GAP→FLYING transition; hold until the next spawn.
  - timer=FLIGHT_TIME.
- FLYING: duck_active=1.
  - duck_hit=1 → FALLING, round_hits+1, timer=FALL_TIME.
  - Else, timer=0 → duck_escaped pulse (one cycle, coincident with leaving FLYING), then resolve the duck.
  - duck_hit and timer=0 in the same cycle → the hit wins; no escape pulse.
- FALLING: duck_active=0. duck_hit is ignored. When the timer reaches 0, resolve the duck.
- Resolve (on the exit transition): duck_idx+1.
  - If the new duck_idx == DUCKS_PER_ROUND → ROUND_END.
  - Else → GAP with timer=GAP_TIME.
- ROUND_END (single cycle):
  - round_hits ≥ HITS_TO_PASS and round < MAX_ROUNDS → round+1, duck_idx=0, round_hits=0, go to GAP.
  - round_hits ≥ HITS_TO_PASS and round == MAX_ROUNDS → GAME_OVER, game_won=1.
  - Otherwise → GAME_OVER, game_won=0.
- GAME_OVER: game_over=1. round, round_hits and game_won hold. Stay until game_enable=0, then go to IDLE.
- duck_hit outside FLYING is ignored.
- Abort: game_enable=0 in any non-IDLE state → IDLE on the next cycle; all counters cleared. A pending pulse is not emitted.
- Counters never wrap: round ≤ MAX_ROUNDS, duck_idx ≤ DUCKS_PER_ROUND, round_hits ≤ DUCKS_PER_ROUND.

Optional Feature:
DUCK_SPEEDUP_EN: when defined, the flight timer load is FLIGHT_TIME − (round−1)×FLIGHT_STEP, saturating at FLIGHT_MIN. This adds parameters FLIGHT_STEP (default 30) and FLIGHT_MIN (default 100); the computation must not underflow. When undefined, every round uses FLIGHT_TIME and these parameters are absent.

Test Plan:
- Reset with game_enable=1 held → all outputs 0 during reset. One cycle after release state=GAP, round=1. spawn_valid pulses 11 cycles later (GAP_TIME=10).
- lfsr_number=1000 at spawn → spawn_x=488. lfsr_number=927 → spawn_x=927.
- No hits for a full round → 10 duck_escaped pulses, each 401 cycles after its spawn_valid. Then game_over=1, game_won=0, round=1.
- duck_hit on the same cycle the flight timer hits 0 → round_hits increments and no duck_escaped pulse. FALLING lasts 21 cycles. duck_hit during FALLING is ignored.
- 6 hits in every round through round 9 → round steps 1..9. Ends with game_over=1, game_won=1. Drop game_enable → IDLE, all outputs 0.
- With DUCK_SPEEDUP_EN: round 5 flight = 400−4×30 = 280 cycles; round 9 flight = 160 cycles (floor 100 not reached). Drop game_enable mid-FLYING in round 3 → IDLE next cycle, round=0, no escape pulse.
